icache_fetch_req_ctrl: RTL and testbench
========================================

Name: icache_fetch_req_ctrl

Overview:
- Sequences instruction-cache read requests on behalf of the fetch pipeline.
- Admits new requests only when every returning word is guaranteed a storage slot.
- Tracks in-flight requests and, on a pipeline flush, counts the outstanding responses that are now stale and silently drops their data_ok beats.
- Returns surviving 64-bit fetch words (two instructions) in order through a small response FIFO with a valid/ready handshake to the next fetch stage.

Parameters:
- MAX_INFLIGHT, 2, maximum number of requests accepted by the icache but not yet answered (>=1).
- DATA_W, 64, width of the icache read data and of resp_data_o.
- CNT_W, 2, width of all counters; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  fetch stage has a request to issue this cycle.
- req_ready_o  out  1  request accepted this cycle (issue handshake complete).
- icache_req_o  out  1  request strobe to the icache.
- icache_addr_ok_i  in  1  icache accepted the request.
- icache_data_ok_i  in  1  icache returns the data for the oldest in-flight request.
- icache_rdata_i  in  DATA_W  icache return data.
- flush_i  in  1  pipeline flush (exception or branch); all older fetches are stale.
- resp_valid_o  out  1  head of the response FIFO is valid.
- resp_data_o  out  DATA_W  head of the response FIFO.
- resp_ready_i  in  1  next stage consumes the FIFO head.
- inflight_o  out  CNT_W  current in-flight count, including stale requests.
- discard_o  out  CNT_W  number of pending data_ok beats that will be dropped.
- error_o  out  1  sticky protocol error.

Behaviour:
- Reset: inflight=0, discard=0, FIFO empty, error=0. Therefore resp_valid_o=0, resp_data_o=0, inflight_o=0, discard_o=0, error_o=0. icache_req_o and req_ready_o are 0 whenever req_valid_i=0.
- Issue condition (combinational): icache_req_o = req_valid_i & ~flush_i & (inflight + fifo_count < MAX_INFLIGHT). This reserves a FIFO slot for every outstanding live response.
- req_ready_o = icache_req_o & icache_addr_ok_i. The issue event is this same term.
- Inflight update: inflight_next = inflight + issue - data_ok. If an issue and a data_ok occur in the same cycle, inflight is unchanged.
- Discard update:
  - When flush_i=0 and discard>0, each data_ok decrements discard and the data is not written to the FIFO.
  - When discard=0 and data_ok=1, icache_rdata_i is pushed into the FIFO.
  - When flush_i=1: discard_next = inflight - data_ok, which equals inflight_next because no issue is possible in a flush cycle. Any data_ok in the flush cycle is dropped. The FIFO is cleared (fifo_count_next=0) and no pop occurs.
- Response latency: data_ok at cycle t makes the word visible on resp_data_o at t+1. There is no bypass.
- FIFO: depth MAX_INFLIGHT, ordered, pointers wrap modulo MAX_INFLIGHT.
  - Pop when resp_valid_o & resp_ready_i & ~flush_i.
  - Push and pop in the same cycle: both happen and the count is unchanged.
  - Push while the FIFO is full cannot occur because of the issue rule; if it does, set error.
- Requests issued after a flush are live. Their responses arrive after all stale ones (icache returns in order), so they are pushed once discard reaches 0.
- error_o is registered and sticky until rst. It sets on any of:
  - data_ok while inflight=0;
  - push into a full FIFO;
  - discard > inflight.
- rst has priority over flush_i and all other inputs in the same cycle. After a mid-operation reset, any late data_ok is treated as the error case (inflight=0).

Test Plan:
- Back-to-back issue, MAX_INFLIGHT=2, addr_ok=1, resp_ready=1: cycles 0–1 issue; data_ok with A at t=2 and B at t=3 -> resp A at t=3, B at t=4. inflight goes 1,2,1,0; third request blocked at inflight=2.
- Downstream stall: resp_ready=0, two data_ok (A,B) -> FIFO holds 2, icache_req_o=0 with req_valid_i=1. Set resp_ready=1 -> A then B on consecutive cycles, then issue resumes.
- Flush with 2 in flight, no data_ok that cycle -> discard=2. Next two data_ok dropped, resp_valid_o stays 0. A request issued during this window returns its word normally afterwards.
- Flush in the same cycle as data_ok with inflight=2 -> discard=1, FIFO cleared, that data dropped, the following data_ok also dropped, discard=0.
- Simultaneous issue and data_ok with inflight=1 -> inflight stays 1, the word is pushed, resp_valid_o=1 next cycle.
- data_ok with inflight=0 after reset -> error_o=1 next cycle and held until rst=1, which clears it in one cycle.

Source files
------------

// File: rtl/icache_fetch_req_ctrl_if.sv
// Handshake bundle between the fetch pipeline, the icache and the next fetch stage.
// The slave modport is the controller's view; the master modport drives the controller.
interface icache_fetch_req_ctrl_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 2
) ();
  logic              req_valid_i;
  logic              req_ready_o;
  logic              icache_req_o;
  logic              icache_addr_ok_i;
  logic              icache_data_ok_i;
  logic [DATA_W-1:0] icache_rdata_i;
  logic              flush_i;
  logic              resp_valid_o;
  logic [DATA_W-1:0] resp_data_o;
  logic              resp_ready_i;
  logic [CNT_W-1:0]  inflight_o;
  logic [CNT_W-1:0]  discard_o;
  logic              error_o;

  modport slave (
    input  req_valid_i, icache_addr_ok_i, icache_data_ok_i, icache_rdata_i,
           flush_i, resp_ready_i,
    output req_ready_o, icache_req_o, resp_valid_o, resp_data_o,
           inflight_o, discard_o, error_o
  );

  modport master (
    output req_valid_i, icache_addr_ok_i, icache_data_ok_i, icache_rdata_i,
           flush_i, resp_ready_i,
    input  req_ready_o, icache_req_o, resp_valid_o, resp_data_o,
           inflight_o, discard_o, error_o
  );
endinterface

// File: rtl/icache_fetch_req_ctrl.sv
// Icache fetch request sequencer: admits requests only when a response slot is reserved,
// drops stale beats after a flush and returns live words in order through a small FIFO.
module icache_fetch_req_ctrl #(
  parameter int MAX_INFLIGHT = 2,
  parameter int DATA_W       = 64,
  parameter int CNT_W        = 2
) (
  input logic                    clk,
  input logic                    rst,
  icache_fetch_req_ctrl_if.slave bus
);
  localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [CNT_W-1:0]  inflight_q, discard_q, count_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] mem_q [MAX_INFLIGHT];
  logic              error_q;

  logic [CNT_W:0]    occupancy;
  logic              icache_req, issue, data_ok, retire;
  logic              fifo_full, resp_valid, pop, push_req, push, drop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Live in-flight requests plus buffered words must never exceed the FIFO depth,
  // so every returning word already owns a slot when it is issued.
  assign occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
  assign icache_req = bus.req_valid_i & ~bus.flush_i &
                      (occupancy < (CNT_W + 1)'(MAX_INFLIGHT));
  assign issue      = icache_req & bus.icache_addr_ok_i;
  assign data_ok    = bus.icache_data_ok_i;
  assign retire     = data_ok & (inflight_q != '0);

  assign fifo_full  = (count_q == CNT_W'(MAX_INFLIGHT));
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid & bus.resp_ready_i & ~bus.flush_i;
  assign push_req   = data_ok & ~bus.flush_i & (discard_q == '0);
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = data_ok & ~bus.flush_i & (discard_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of its neighbours, independent of statement order.
      inflight_q <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(retire);

      if (bus.flush_i)  discard_q <= inflight_q - CNT_W'(retire);
      else if (drop)    discard_q <= discard_q - 1'b1;

      if (bus.flush_i) begin
        count_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end

      error_q <= error_q | (data_ok & (inflight_q == '0)) |
                 (push_req & fifo_full) | (discard_q > inflight_q);
    end
  end

  // NOTE: the storage array carries no reset; its contents are only observable
  // through resp_data_o, which is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.icache_rdata_i;
  end

  assign bus.icache_req_o = icache_req;
  assign bus.req_ready_o  = issue;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_data_o  = resp_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.inflight_o   = inflight_q;
  assign bus.discard_o    = discard_q;
  assign bus.error_o      = error_q;
endmodule

// File: tb/tb_icache_fetch_req_ctrl.sv
// Directed bench for icache_fetch_req_ctrl: issue gating, in-order return, stall,
// flush discard handling, simultaneous issue/return and the sticky error flag.
module tb_icache_fetch_req_ctrl;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 2;

  localparam logic [DATA_W-1:0] W_A = 64'hA0A0_0001_A0A0_0002;
  localparam logic [DATA_W-1:0] W_B = 64'hB0B0_0003_B0B0_0004;
  localparam logic [DATA_W-1:0] W_C = 64'hC0C0_0005_C0C0_0006;
  localparam logic [DATA_W-1:0] W_D = 64'hD0D0_0007_D0D0_0008;
  localparam logic [DATA_W-1:0] W_E = 64'hE0E0_0009_E0E0_000A;
  localparam logic [DATA_W-1:0] W_X = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [DATA_W-1:0] W_I = 64'h1111_2222_3333_4444;
  localparam logic [DATA_W-1:0] W_J = 64'h5555_6666_7777_8888;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  icache_fetch_req_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  icache_fetch_req_ctrl #(.MAX_INFLIGHT(2), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i      = 1'b0;
    bus.icache_addr_ok_i = 1'b0;
    bus.icache_data_ok_i = 1'b0;
    bus.icache_rdata_i   = '0;
    bus.flush_i          = 1'b0;
    bus.resp_ready_i     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%0b exp=0", bus.resp_valid_o); end
    checks++; if (bus.resp_data_o !== 64'h0) begin errors++; $display("FAIL reset_resp_data got=%h exp=0", bus.resp_data_o); end
    checks++; if (bus.inflight_o !== 2'd0) begin errors++; $display("FAIL reset_inflight got=%0d exp=0", bus.inflight_o); end
    checks++; if (bus.discard_o !== 2'd0) begin errors++; $display("FAIL reset_discard got=%0d exp=0", bus.discard_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL reset_error got=%0b exp=0", bus.error_o); end
    checks++; if (bus.icache_req_o !== 1'b0) begin errors++; $display("FAIL reset_icache_req got=%0b exp=0", bus.icache_req_o); end
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%0b exp=0", bus.req_ready_o); end
    bus.req_valid_i = 1'b1;
    #1;
    checks++; if (bus.icache_req_o !== 1'b1) begin errors++; $display("FAIL reset_req_strobe got=%0b exp=1", bus.icache_req_o); end
    checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_no_addr_ok got=%0b exp=0", bus.req_ready_o); end
    bus.req_valid_i = 1'b0;
    #1;
  endtask

  task automatic test_back_to_back();
    bus.req_valid_i = 1'b1; bus.icache_addr_ok_i = 1'b1; bus.resp_ready_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_issue0 got=%0b exp=1", bus.req_ready_o); end
    tick();
    checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL b2b_inflight_1 got=%0d exp=1", bus.inflight_o); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_issue1 got=%0b exp=1", bus.req_ready_o); end
    tick();
    checks++; if (bus.inflight_o !== 2'd2) begin errors++; $display("FAIL b2b_inflight_2 got=%0d exp=2", bus.inflight_o); end
    checks++; if (bus.icache_req_o !== 1'b0) begin errors++; $display("FAIL b2b_third_blocked got=%0b exp=0", bus.icache_req_o); end
    bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_A;
    tick();
    checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL b2b_inflight_after_a got=%0d exp=1", bus.inflight_o); end
    checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== W_A) begin errors++; $display("FAIL b2b_resp_a got=%0b/%h exp=1/%h", bus.resp_valid_o, bus.resp_data_o, W_A); end
    checks++; if (bus.icache_req_o !== 1'b0) begin errors++; $display("FAIL b2b_blocked_by_slot got=%0b exp=0", bus.icache_req_o); end
    bus.icache_rdata_i = W_B;
    tick();
    bus.req_valid_i = 1'b0; bus.icache_data_ok_i = 1'b0;
    checks++; if (bus.inflight_o !== 2'd0) begin errors++; $display("FAIL b2b_inflight_after_b got=%0d exp=0", bus.inflight_o); end
    checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== W_B) begin errors++; $display("FAIL b2b_resp_b got=%0b/%h exp=1/%h", bus.resp_valid_o, bus.resp_data_o, W_B); end
    tick();
    checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0b exp=0", bus.resp_valid_o); end
  endtask

  task automatic test_stall();
    bus.resp_ready_i = 1'b0; bus.req_valid_i = 1'b1; bus.icache_addr_ok_i = 1'b1;
    tick();
    tick();
    bus.req_valid_i = 1'b0; bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_C;
    tick();
    bus.icache_rdata_i = W_D;
    tick();
    bus.icache_data_ok_i = 1'b0; bus.req_valid_i = 1'b1;
    #1;
    checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== W_C) begin errors++; $display("FAIL stall_head_c got=%0b/%h exp=1/%h", bus.resp_valid_o, bus.resp_data_o, W_C); end
    checks++; if (bus.inflight_o !== 2'd0) begin errors++; $display("FAIL stall_inflight got=%0d exp=0", bus.inflight_o); end
    checks++; if (bus.icache_req_o !== 1'b0) begin errors++; $display("FAIL stall_fifo_full_blocks got=%0b exp=0", bus.icache_req_o); end
    bus.req_valid_i = 1'b0; bus.resp_ready_i = 1'b1;
    tick();
    checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== W_D) begin errors++; $display("FAIL stall_head_d got=%0b/%h exp=1/%h", bus.resp_valid_o, bus.resp_data_o, W_D); end
    tick();
    checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drained got=%0b exp=0", bus.resp_valid_o); end
    bus.req_valid_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_issue_resumes got=%0b exp=1", bus.req_ready_o); end
    bus.req_valid_i = 1'b0;
    #1;
  endtask

  task automatic test_flush_idle();
    bus.resp_ready_i = 1'b1; bus.icache_addr_ok_i = 1'b1; bus.req_valid_i = 1'b1;
    tick();
    tick();
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.icache_req_o !== 1'b0) begin errors++; $display("FAIL flush_blocks_issue got=%0b exp=0", bus.icache_req_o); end
    tick();
    bus.flush_i = 1'b0; bus.req_valid_i = 1'b0;
    checks++; if (bus.discard_o !== 2'd2 || bus.inflight_o !== 2'd2) begin errors++; $display("FAIL flush_discard2 got=%0d/%0d exp=2/2", bus.discard_o, bus.inflight_o); end
    bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_X;
    tick();
    checks++; if (bus.discard_o !== 2'd1 || bus.inflight_o !== 2'd1 || bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop1 got=%0d/%0d/%0b exp=1/1/0", bus.discard_o, bus.inflight_o, bus.resp_valid_o); end
    bus.req_valid_i = 1'b1;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL flush_window_issue got=%0b exp=1", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 1'b0;
    checks++; if (bus.discard_o !== 2'd0 || bus.inflight_o !== 2'd1 || bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drop2 got=%0d/%0d/%0b exp=0/1/0", bus.discard_o, bus.inflight_o, bus.resp_valid_o); end
    bus.icache_rdata_i = W_E;
    tick();
    bus.icache_data_ok_i = 1'b0;
    checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== W_E) begin errors++; $display("FAIL flush_live_word got=%0b/%h exp=1/%h", bus.resp_valid_o, bus.resp_data_o, W_E); end
    tick();
    checks++; if (bus.resp_valid_o !== 1'b0 || bus.inflight_o !== 2'd0) begin errors++; $display("FAIL flush_idle_end got=%0b/%0d exp=0/0", bus.resp_valid_o, bus.inflight_o); end
  endtask

  task automatic test_flush_data_ok();
    bus.resp_ready_i = 1'b1; bus.icache_addr_ok_i = 1'b1; bus.req_valid_i = 1'b1;
    tick();
    tick();
    bus.req_valid_i = 1'b0; bus.flush_i = 1'b1; bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_X;
    tick();
    bus.flush_i = 1'b0;
    checks++; if (bus.discard_o !== 2'd1 || bus.inflight_o !== 2'd1 || bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL flushdok_first got=%0d/%0d/%0b exp=1/1/0", bus.discard_o, bus.inflight_o, bus.resp_valid_o); end
    tick();
    bus.icache_data_ok_i = 1'b0;
    checks++; if (bus.discard_o !== 2'd0 || bus.inflight_o !== 2'd0 || bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL flushdok_second got=%0d/%0d/%0b exp=0/0/0", bus.discard_o, bus.inflight_o, bus.resp_valid_o); end
    // Buffered word plus one in flight, then flush with a data_ok: both vanish.
    bus.resp_ready_i = 1'b0; bus.req_valid_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0; bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_C;
    tick();
    bus.icache_data_ok_i = 1'b0; bus.req_valid_i = 1'b1;
    checks++; if (bus.resp_valid_o !== 1'b1) begin errors++; $display("FAIL flushdok_buffered got=%0b exp=1", bus.resp_valid_o); end
    tick();
    bus.req_valid_i = 1'b0; bus.flush_i = 1'b1; bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_X;
    tick();
    bus.flush_i = 1'b0; bus.icache_data_ok_i = 1'b0; bus.resp_ready_i = 1'b1;
    checks++; if (bus.resp_valid_o !== 1'b0 || bus.inflight_o !== 2'd0 || bus.discard_o !== 2'd0) begin errors++; $display("FAIL flushdok_fifo_clear got=%0b/%0d/%0d exp=0/0/0", bus.resp_valid_o, bus.inflight_o, bus.discard_o); end
    checks++; if (bus.error_o !== 1'b0) begin errors++; $display("FAIL flushdok_no_error got=%0b exp=0", bus.error_o); end
  endtask

  task automatic test_simultaneous();
    bus.resp_ready_i = 1'b1; bus.icache_addr_ok_i = 1'b1; bus.req_valid_i = 1'b1;
    tick();
    bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_I;
    #1;
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL simul_issue got=%0b exp=1", bus.req_ready_o); end
    tick();
    bus.req_valid_i = 1'b0; bus.icache_rdata_i = W_J;
    checks++; if (bus.inflight_o !== 2'd1) begin errors++; $display("FAIL simul_inflight_held got=%0d exp=1", bus.inflight_o); end
    checks++; if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== W_I) begin errors++; $display("FAIL simul_resp_i got=%0b/%h exp=1/%h", bus.resp_valid_o, bus.resp_data_o, W_I); end
    tick();
    bus.icache_data_ok_i = 1'b0;
    checks++; if (bus.inflight_o !== 2'd0 || bus.resp_data_o !== W_J) begin errors++; $display("FAIL simul_resp_j got=%0d/%h exp=0/%h", bus.inflight_o, bus.resp_data_o, W_J); end
    tick();
    checks++; if (bus.resp_valid_o !== 1'b0 || bus.error_o !== 1'b0) begin errors++; $display("FAIL simul_end got=%0b/%0b exp=0/0", bus.resp_valid_o, bus.error_o); end
  endtask

  task automatic test_error();
    bus.icache_data_ok_i = 1'b1; bus.icache_rdata_i = W_X;
    tick();
    bus.icache_data_ok_i = 1'b0;
    checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL error_set got=%0b exp=1", bus.error_o); end
    tick();
    tick();
    checks++; if (bus.error_o !== 1'b1) begin errors++; $display("FAIL error_sticky got=%0b exp=1", bus.error_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.error_o !== 1'b0 || bus.resp_valid_o !== 1'b0 || bus.inflight_o !== 2'd0) begin errors++; $display("FAIL error_cleared got=%0b/%0b/%0d exp=0/0/0", bus.error_o, bus.resp_valid_o, bus.inflight_o); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_flush_idle();
    test_flush_data_ok();
    test_simultaneous();
    test_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
